// File: rtl/krnl_vadd_adder_tree_if.sv
// rtl/krnl_vadd_adder_tree_if.sv - stream signals between the data generator, the adder stage and the result receiver
interface krnl_vadd_adder_tree_if #(
  parameter int C_DATA_WIDTH = 32
);
  logic [1:0]                s_tvalid;
  logic [2*C_DATA_WIDTH-1:0] s_tdata;
  logic                      s_tready;
  logic                      m_tvalid;
  logic [C_DATA_WIDTH:0]     m_tdata;
  logic                      m_tready;

  // Adder stage view: consumes the operand stream, produces the sum stream
  modport slave (
    input  s_tvalid, s_tdata, m_tready,
    output s_tready, m_tvalid, m_tdata
  );

  // Surrounding environment view: produces operands, consumes sums
  modport master (
    output s_tvalid, s_tdata, m_tready,
    input  s_tready, m_tvalid, m_tdata
  );
endinterface

// File: rtl/krnl_vadd_adder_tree.sv
// rtl/krnl_vadd_adder_tree.sv - two-lane stream adder with a 2-entry result FIFO
module krnl_vadd_adder_tree #(
  parameter int C_DATA_WIDTH = 32
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  krnl_vadd_adder_tree_if.slave bus
);
  localparam int RW = C_DATA_WIDTH + 1;

  logic [RW-1:0] mem_q [2];
  logic [RW-1:0] mem_d [2];
  logic          wr_ptr_q, wr_ptr_d;
  logic          rd_ptr_q, rd_ptr_d;
  logic [1:0]    count_q, count_d;
  // Held low through reset so s_tready only rises on the first edge after release
  logic          rdy_en_q, rdy_en_d;

  logic          accept;
  logic          pop;
  logic [RW-1:0] sum;

  // Ready depends only on registered state, never on s_tvalid
  assign bus.s_tready = rdy_en_q && (count_q != 2'd2);
  assign bus.m_tvalid = (count_q != 2'd0);
  assign bus.m_tdata  = mem_q[rd_ptr_q];

  // Next-state: a beat transfers only with both lanes valid; sum carries into the MSB
  always_comb begin
    sum      = {1'b0, bus.s_tdata[C_DATA_WIDTH-1:0]}
             + {1'b0, bus.s_tdata[2*C_DATA_WIDTH-1:C_DATA_WIDTH]};
    accept   = (bus.s_tvalid == 2'b11) && bus.s_tready;
    pop      = bus.m_tvalid && bus.m_tready;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    rdy_en_d = 1'b1;
    if (accept) begin
      mem_d[wr_ptr_q] = sum;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({accept, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // State registers; reset empties the FIFO and zeroes storage so m_tdata reads 0
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      rdy_en_q <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rdy_en_q <= rdy_en_d;
    end
  end
endmodule

// File: tb/tb_krnl_vadd_adder_tree.sv
// tb/tb_krnl_vadd_adder_tree.sv - directed and random checks of the adder stage against a queue model
module tb_krnl_vadd_adder_tree;
  logic aclk;
  logic aresetn;

  krnl_vadd_adder_tree_if #(.C_DATA_WIDTH(32)) bus ();

  krnl_vadd_adder_tree #(.C_DATA_WIDTH(32)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int          n_cmp;
  int          n_bad;
  int          n_pop;
  logic [32:0] exp_q[$];
  logic        rdy_m;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs at the falling edge, then advance the queue model at the rising edge
  task automatic tick();
    logic        acc;
    logic        pp;
    logic [32:0] s;
    @(negedge aclk);
    chk("s_tready", bus.s_tready, rdy_m && (exp_q.size() < 2));
    chk("m_tvalid", bus.m_tvalid, exp_q.size() != 0);
    if (exp_q.size() != 0) chk("m_tdata", bus.m_tdata, exp_q[0]);
    acc = aresetn && rdy_m && (exp_q.size() < 2) && (bus.s_tvalid == 2'b11);
    pp  = aresetn && (exp_q.size() != 0) && bus.m_tready;
    s   = 33'(bus.s_tdata[31:0]) + 33'(bus.s_tdata[63:32]);
    @(posedge aclk);
    if (!aresetn) begin
      exp_q.delete();
      rdy_m = 1'b0;
    end else begin
      if (pp) begin
        void'(exp_q.pop_front());
        n_pop++;
      end
      if (acc) exp_q.push_back(s);
      rdy_m = 1'b1;
    end
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [31:0] l1, input logic [31:0] l0);
    bus.s_tvalid = v;
    bus.s_tdata  = {l1, l0};
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    n_pop = 0;
    rdy_m = 1'b0;
    aresetn      = 1'b0;
    bus.m_tready = 1'b1;
    drive(2'b11, 32'd7, 32'd9);

    // Reset held with valid asserted
    repeat (2) tick();
    chk("rst_m_tdata", bus.m_tdata, 33'h0);
    aresetn = 1'b1;
    drive(2'b00, 32'd0, 32'd0);
    tick();
    chk("rel_s_tready", bus.s_tready, 1'b1);

    // Single add with 1-cycle latency
    drive(2'b11, 32'h2, 32'h3);
    tick();
    drive(2'b00, 32'd0, 32'd0);
    chk("single_valid", bus.m_tvalid, 1'b1);
    chk("single_data", bus.m_tdata, 33'h0_00000005);
    tick();
    chk("single_empty", bus.m_tvalid, 1'b0);

    // Carry into the MSB
    drive(2'b11, 32'h1, 32'hFFFF_FFFF);
    tick();
    chk("carry1", bus.m_tdata, 33'h1_0000_0000);
    drive(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    tick();
    chk("carry2", bus.m_tdata, 33'h1_FFFF_FFFE);
    drive(2'b00, 32'd0, 32'd0);
    tick();

    // Partial valid never transfers
    for (int i = 0; i < 5; i++) begin
      drive((i % 2 == 0) ? 2'b01 : 2'b10, 32'd20, 32'd10);
      tick();
      chk("partial_idle", bus.m_tvalid, 1'b0);
    end
    drive(2'b11, 32'd20, 32'd10);
    tick();
    drive(2'b00, 32'd0, 32'd0);
    chk("partial_sum", bus.m_tdata, 33'd30);
    tick();
    chk("partial_once", bus.m_tvalid, 1'b0);

    // Backpressure fills the buffer then drains in order
    bus.m_tready = 1'b0;
    drive(2'b11, 32'd1, 32'd1);
    tick();
    drive(2'b11, 32'd2, 32'd2);
    tick();
    chk("bp_full", bus.s_tready, 1'b0);
    drive(2'b11, 32'd3, 32'd3);
    tick();
    chk("bp_stall", bus.m_tdata, 33'd2);
    bus.m_tready = 1'b1;
    tick();
    chk("bp_second", bus.m_tdata, 33'd4);
    tick();
    drive(2'b00, 32'd0, 32'd0);
    chk("bp_third", bus.m_tdata, 33'd6);
    tick();

    // Continuous streaming, one result per cycle
    n_pop = 0;
    for (int k = 0; k < 32; k++) begin
      drive(2'b11, 32'(k), 32'(k));
      tick();
    end
    drive(2'b00, 32'd0, 32'd0);
    tick();
    chk("stream_count", 64'(n_pop), 64'd32);

    // Reset with two buffered entries
    bus.m_tready = 1'b0;
    drive(2'b11, 32'd5, 32'd5);
    tick();
    drive(2'b11, 32'd6, 32'd6);
    tick();
    chk("pre_rst_full", bus.s_tready, 1'b0);
    aresetn = 1'b0;
    #1;
    exp_q.delete();
    rdy_m = 1'b0;
    chk("async_m_tvalid", bus.m_tvalid, 1'b0);
    chk("async_s_tready", bus.s_tready, 1'b0);
    chk("async_m_tdata", bus.m_tdata, 33'h0);
    bus.m_tready = 1'b1;
    drive(2'b00, 32'd0, 32'd0);
    repeat (2) tick();
    aresetn = 1'b1;
    repeat (4) tick();

    // Random operands, valid patterns and backpressure
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      logic [31:0] b;
      a = $urandom();
      b = $urandom();
      if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFFF;
      if ($urandom_range(0, 7) == 0) b = 32'hFFFF_FFFF;
      drive(2'($urandom_range(0, 3)), b, a);
      bus.m_tready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drive(2'b00, 32'd0, 32'd0);
    bus.m_tready = 1'b1;
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
